// File: rtl/ddram_arb_if.sv
// ddram_arb_if: signal bundle between two core-side clients, the arbiter and
// the shared 64-bit DDR3 Avalon-MM port (ram1).
//   c0_* / c1_*  : client command, write data, busy (waitrequest) and read return
//   ram_*        : Avalon-MM master side toward the DDR controller
// Modports:
//   slave  - the arbiter: consumes client requests and ram responses, drives
//            busy/read return and the ram command
//   master - the environment: drives client requests and ram responses
interface ddram_arb_if #(
  parameter int AW = 29,
  parameter int BW = 8
);
  logic [AW-1:0] c0_addr,     c1_addr;
  logic [BW-1:0] c0_burstcnt, c1_burstcnt;
  logic          c0_rd,       c1_rd;
  logic          c0_we,       c1_we;
  logic [63:0]   c0_din,      c1_din;
  logic [7:0]    c0_be,       c1_be;
  logic          c0_busy,     c1_busy;
  logic [63:0]   c0_dout,     c1_dout;
  logic          c0_dout_ready, c1_dout_ready;

  logic [AW-1:0] ram_address;
  logic [BW-1:0] ram_burstcount;
  logic          ram_read;
  logic          ram_write;
  logic [63:0]   ram_writedata;
  logic [7:0]    ram_byteenable;
  logic          ram_waitrequest;
  logic [63:0]   ram_readdata;
  logic          ram_readdatavalid;

  modport slave (
    input  c0_addr, c1_addr, c0_burstcnt, c1_burstcnt, c0_rd, c1_rd,
           c0_we, c1_we, c0_din, c1_din, c0_be, c1_be,
           ram_waitrequest, ram_readdata, ram_readdatavalid,
    output c0_busy, c1_busy, c0_dout, c1_dout, c0_dout_ready, c1_dout_ready,
           ram_address, ram_burstcount, ram_read, ram_write, ram_writedata,
           ram_byteenable
  );

  modport master (
    output c0_addr, c1_addr, c0_burstcnt, c1_burstcnt, c0_rd, c1_rd,
           c0_we, c1_we, c0_din, c1_din, c0_be, c1_be,
           ram_waitrequest, ram_readdata, ram_readdatavalid,
    input  c0_busy, c1_busy, c0_dout, c1_dout, c0_dout_ready, c1_dout_ready,
           ram_address, ram_burstcount, ram_read, ram_write, ram_writedata,
           ram_byteenable
  );
endinterface

// File: rtl/ddram_arb.sv
// ddram_arb: two-client arbiter for the single 64-bit DDR3 Avalon-MM port.
// Grants whole write or read bursts atomically, returns read data only to the
// owning client, and alternates ownership when both clients request.
// Ports:
//   clk     - DDRAM clock
//   reset_n - synchronous, active-low reset
//   bus     - ddram_arb_if.slave (client c0/c1 signals and ram_* port)
// Build option:
//   DDRAM_ARB_PRIO_EN - when defined, client 0 always wins ties (fixed
//                       priority); otherwise ties go round-robin.
module ddram_arb #(
  parameter int AW = 29,
  parameter int BW = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  ddram_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_DATA} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [BW-1:0] len_q,   len_d;
  logic [BW:0]   cnt_q,   cnt_d;    // one extra bit so a max-length burst never wraps
`ifndef DDRAM_ARB_PRIO_EN
  logic          last_q,  last_d;
`endif

  // Owner-selected client fields
  logic          o_rd, o_we;
  logic [AW-1:0] o_addr;
  logic [BW-1:0] o_bc;
  logic [63:0]   o_din;
  logic [7:0]    o_be;

  logic          req0, req1, gnt, g_we;
  logic [BW-1:0] g_bc;
  logic          own_busy, own_rdy, last_beat;
  logic [BW:0]   cnt_inc;

  always_comb begin
    o_rd   = owner_q ? bus.c1_rd       : bus.c0_rd;
    o_we   = owner_q ? bus.c1_we       : bus.c0_we;
    o_addr = owner_q ? bus.c1_addr     : bus.c0_addr;
    o_bc   = owner_q ? bus.c1_burstcnt : bus.c0_burstcnt;
    o_din  = owner_q ? bus.c1_din      : bus.c0_din;
    o_be   = owner_q ? bus.c1_be       : bus.c0_be;
  end

  assign req0      = bus.c0_rd | bus.c0_we;
  assign req1      = bus.c1_rd | bus.c1_we;
  assign cnt_inc   = cnt_q + (BW+1)'(1);
  assign last_beat = (cnt_inc == {1'b0, len_q});

  // Tie-break: fixed priority favours c0; round-robin favours the client
  // that did not own the previous burst.
`ifdef DDRAM_ARB_PRIO_EN
  assign gnt = ~req0;
`else
  assign gnt = (req0 & req1) ? ~last_q : req1;
`endif
  assign g_we = gnt ? bus.c1_we       : bus.c0_we;
  assign g_bc = gnt ? bus.c1_burstcnt : bus.c0_burstcnt;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
`ifndef DDRAM_ARB_PRIO_EN
    last_d        = last_q;
`endif
    own_busy      = 1'b1;
    own_rdy       = 1'b0;
    bus.ram_read  = 1'b0;
    bus.ram_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = gnt;
`ifndef DDRAM_ARB_PRIO_EN
          last_d  = gnt;
`endif
          len_d   = (g_bc == '0) ? BW'(1) : g_bc;
          cnt_d   = '0;
          state_d = g_we ? WR : RD_CMD;   // write wins if both rd and we
        end
      end
      WR: begin
        bus.ram_write = o_we;
        own_busy      = bus.ram_waitrequest;
        if (o_we && !bus.ram_waitrequest) begin
          cnt_d = cnt_inc;
          if (last_beat) state_d = IDLE;
        end
      end
      RD_CMD: begin
        bus.ram_read = o_rd;
        own_busy     = bus.ram_waitrequest;
        // Dropping rd before acceptance abandons the burst.
        if (!o_rd) state_d = IDLE;
        else if (!bus.ram_waitrequest) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (bus.ram_readdatavalid) begin
          own_rdy = 1'b1;
          cnt_d   = cnt_inc;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ram_address    = o_addr;
  assign bus.ram_burstcount = o_bc;
  assign bus.ram_writedata  = o_din;
  assign bus.ram_byteenable = o_be;

  assign bus.c0_busy       = owner_q ? 1'b1 : own_busy;
  assign bus.c1_busy       = owner_q ? own_busy : 1'b1;
  assign bus.c0_dout_ready = ~owner_q & own_rdy;
  assign bus.c1_dout_ready =  owner_q & own_rdy;
  assign bus.c0_dout       = bus.ram_readdata;
  assign bus.c1_dout       = bus.ram_readdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      len_q   <= BW'(1);
      cnt_q   <= '0;
`ifndef DDRAM_ARB_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
`ifndef DDRAM_ARB_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_ddram_arb.sv
// Self-checking bench for ddram_arb. Write beats and read returns are
// predicted into queues as stimulus is driven and popped by a negedge
// monitor whenever the DUT accepts a write beat or flags read data.
module tb_ddram_arb;
  localparam int AW = 29;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ddram_arb_if #(.AW(AW), .BW(BW)) bus ();
  ddram_arb #(.AW(AW), .BW(BW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct packed {logic cli; logic [63:0] data;} rd_exp_t;

  int n_tests = 0;
  int n_fail  = 0;
  rd_exp_t     rdq[$];
  logic [71:0] wrq[$];   // {byteenable, writedata}
  int          wr_acc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);     endtask

  // Monitor: every accepted write beat and every read return must match the
  // next prediction.
  always @(negedge clk) begin
    rd_exp_t     e;
    logic [71:0] w;
    if (bus.ram_write && !bus.ram_waitrequest) begin
      wr_acc++;
      chk("wr_pending", 64'(wrq.size() != 0), 1);
      if (wrq.size() != 0) begin
        w = wrq.pop_front();
        chk("wr_data", bus.ram_writedata, w[63:0]);
        chk("wr_be", 64'(bus.ram_byteenable), 64'(w[71:64]));
      end
    end
    if (bus.c0_dout_ready || bus.c1_dout_ready) begin
      chk("rd_pending", 64'(rdq.size() != 0), 1);
      if (rdq.size() != 0) begin
        e = rdq.pop_front();
        chk("rd_route", {bus.c1_dout_ready, bus.c0_dout_ready}, e.cli ? 2'b10 : 2'b01);
        chk("rd_data", e.cli ? bus.c1_dout : bus.c0_dout, e.data);
      end
    end
  end

  task automatic drv(input bit cli, input logic rd, input logic we, input logic [AW-1:0] a,
                     input logic [BW-1:0] bc, input logic [63:0] d);
    if (cli) begin
      bus.c1_rd = rd; bus.c1_we = we; bus.c1_addr = a; bus.c1_burstcnt = bc;
      bus.c1_din = d; bus.c1_be = ~d[7:0];
    end else begin
      bus.c0_rd = rd; bus.c0_we = we; bus.c0_addr = a; bus.c0_burstcnt = bc;
      bus.c0_din = d; bus.c0_be = ~d[7:0];
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(); tick();
    smp();
    chk("rst_c0_busy", bus.c0_busy, 1);
    chk("rst_c1_busy", bus.c1_busy, 1);
    chk("rst_ram_read", bus.ram_read, 0);
    chk("rst_ram_write", bus.ram_write, 0);
    chk("rst_rdy", {bus.c1_dout_ready, bus.c0_dout_ready}, 0);
    tick();
    reset_n = 1'b1;
  endtask

  // Client-side write burst; waitrequest is held for wc cycles at beat wb.
  task automatic wr_burst(input bit cli, input logic [AW-1:0] a, input int n,
                          input logic [63:0] base, input int wb, input int wc, output int cyc);
    int beat = 0, wcnt = 0;
    logic busy;
    logic [63:0] d;
    cyc = 0;
    wr_acc = 0;
    drv(cli, 0, 1, a, BW'(n), base);
    wrq.push_back({~base[7:0], base});
    while (beat < n && cyc < 64) begin
      smp();
      cyc++;
      busy = cli ? bus.c1_busy : bus.c0_busy;
      if (bus.ram_write) begin
        chk("wr_busy_mirror", busy, bus.ram_waitrequest);
        chk("wr_addr", bus.ram_address, a);
      end
      chk("wr_other_busy", cli ? bus.c0_busy : bus.c1_busy, 1);
      tick();
      if (!busy) begin
        beat++;
        d = base + 64'(beat);
        drv(cli, 0, beat < n, a, BW'(n), d);
        if (beat < n) wrq.push_back({~d[7:0], d});
      end
      bus.ram_waitrequest = (beat == wb) && (wcnt < wc);
      if (bus.ram_waitrequest) wcnt++;
    end
    chk("wr_done", beat, n);
    smp();
    chk("wr_idle_write", bus.ram_write, 0);
    chk("wr_idle_busy", cli ? bus.c1_busy : bus.c0_busy, 1);
    chk("wr_beats", wr_acc, n);
    tick();
  endtask

  // Client-side read: request, wait for acceptance, then return nbeats.
  task automatic rd_burst(input bit cli, input logic [AW-1:0] a, input int bc, input int nbeats,
                          input logic [63:0] base, output int lat);
    bit acc = 0;
    lat = 0;
    drv(cli, 1, 0, a, BW'(bc), 0);
    while (!acc && lat < 32) begin
      smp();
      lat++;
      if (bus.ram_read && !bus.ram_waitrequest) begin
        acc = 1;
        chk("rd_addr", bus.ram_address, a);
        chk("rd_bc", bus.ram_burstcount, bc);
        chk("rd_own_busy", cli ? bus.c1_busy : bus.c0_busy, 0);
      end
      tick();
    end
    chk("rd_accepted", acc, 1);
    drv(cli, 0, 0, a, BW'(bc), 0);
    for (int i = 0; i < nbeats; i++) begin
      rdq.push_back('{cli: cli, data: base + 64'(i)});
      bus.ram_readdatavalid = 1'b1;
      bus.ram_readdata = base + 64'(i);
      smp();
      chk("rd_no_cmd", bus.ram_read, 0);
      tick();
    end
    bus.ram_readdatavalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, lat, guard, exp_o;
    bit acc;
    logic owner;
    drv(0, 0, 0, '0, '0, '0);
    drv(1, 0, 0, '0, '0, '0);
    bus.ram_waitrequest = 1'b0;
    bus.ram_readdata = '0;
    bus.ram_readdatavalid = 1'b0;
    do_reset();

    // Simultaneous reads after reset: c0 first, c1 one IDLE cycle later.
    drv(0, 1, 0, 29'h100, 8'd2, 0);
    drv(1, 1, 0, 29'h200, 8'd2, 0);
    smp();
    chk("tie_idle_busy", {bus.c1_busy, bus.c0_busy}, 2'b11);
    chk("tie_idle_read", bus.ram_read, 0);
    tick(); smp();
    chk("tie_c0_cmd", bus.ram_read, 1);
    chk("tie_c0_addr", bus.ram_address, 29'h100);
    chk("tie_c0_busy", bus.c0_busy, 0);
    chk("tie_c1_busy", bus.c1_busy, 1);
    tick();
    drv(0, 0, 0, 29'h100, 8'd2, 0);
    for (int i = 0; i < 2; i++) begin
      rdq.push_back('{cli: 1'b0, data: 64'hA0A0_0000_0000_0000 + 64'(i)});
      bus.ram_readdatavalid = 1'b1;
      bus.ram_readdata = 64'hA0A0_0000_0000_0000 + 64'(i);
      smp();
      chk("tie_c1_wait", bus.c1_busy, 1);
      tick();
    end
    bus.ram_readdatavalid = 1'b0;
    smp();
    chk("tie_gap_read", bus.ram_read, 0);
    chk("tie_gap_c1_busy", bus.c1_busy, 1);
    tick(); smp();
    chk("tie_c1_cmd", bus.ram_read, 1);
    chk("tie_c1_addr", bus.ram_address, 29'h200);
    chk("tie_c1_own_busy", bus.c1_busy, 0);
    chk("tie_c0_busy2", bus.c0_busy, 1);
    tick();
    drv(1, 0, 0, 29'h200, 8'd2, 0);
    for (int i = 0; i < 2; i++) begin
      rdq.push_back('{cli: 1'b1, data: 64'hB1B1_0000_0000_0000 + 64'(i)});
      bus.ram_readdatavalid = 1'b1;
      bus.ram_readdata = 64'hB1B1_0000_0000_0000 + 64'(i);
      tick();
    end
    bus.ram_readdatavalid = 1'b0;

    // c0 write burst of 4, no wait: IDLE + 4 consecutive beats.
    wr_burst(0, 29'h0AB0, 4, 64'h1111_2222_3333_4400, 99, 0, cyc);
    chk("wr4_cycles", cyc, 5);
    // c0 write burst of 3 with waitrequest held 3 cycles on beat 2.
    wr_burst(0, 29'h0CD0, 3, 64'h5555_6666_7777_8800, 1, 3, cyc);
    chk("wr3_wait_cycles", cyc, 7);
    // c1 write burst of 2 through the owner mux.
    wr_burst(1, 29'h1EF0, 2, 64'h9999_AAAA_BBBB_CC00, 99, 0, cyc);
    chk("wr2_c1_cycles", cyc, 3);

    // Both clients continuously request single-beat reads.
    do_reset();
    drv(0, 1, 0, 29'h300, 8'd1, 0);
    drv(1, 1, 0, 29'h400, 8'd1, 0);
    for (int g = 0; g < 4; g++) begin
      acc = 0; guard = 0; owner = 1'b0;
      while (!acc && guard < 16) begin
        smp();
        guard++;
        if (bus.ram_read && !bus.ram_waitrequest) begin
          acc = 1;
          owner = (bus.ram_address == 29'h400);
        end
        if (!acc) tick();
      end
      chk("rr_grant", acc, 1);
`ifdef DDRAM_ARB_PRIO_EN
      exp_o = 0;
`else
      exp_o = g % 2;
`endif
      chk("rr_owner", owner, exp_o);
      tick();
      rdq.push_back('{cli: exp_o[0], data: 64'hC0DE_0000_0000_0000 + 64'(g)});
      bus.ram_readdatavalid = 1'b1;
      bus.ram_readdata = 64'hC0DE_0000_0000_0000 + 64'(g);
      smp();
      tick();
      bus.ram_readdatavalid = 1'b0;
    end
    drv(0, 0, 0, '0, '0, '0);
    drv(1, 0, 0, '0, '0, '0);
    tick();

    // burstcnt=0 read is one beat; a second valid pulse is not delivered.
    rd_burst(1, 29'h500, 0, 1, 64'hD00D_0000_0000_0000, lat);
    chk("bc0_lat", lat, 2);
    bus.ram_readdatavalid = 1'b1;
    smp();
    chk("bc0_stray_rdy", {bus.c1_dout_ready, bus.c0_dout_ready}, 0);
    chk("bc0_idle_busy", bus.c1_busy, 1);
    tick();
    bus.ram_readdatavalid = 1'b0;

    // Reset during RD_DATA after 1 of 4 beats; stray beats go nowhere.
    rd_burst(0, 29'h600, 4, 1, 64'hE000_0000_0000_0000, lat);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ram_readdatavalid = 1'b1;
      bus.ram_readdata = 64'hEEEE_0000_0000_0000 + 64'(i);
      smp();
      chk("rstmid_rdy", {bus.c1_dout_ready, bus.c0_dout_ready}, 0);
      chk("rstmid_busy", bus.c0_busy, 1);
      tick();
    end
    bus.ram_readdatavalid = 1'b0;
    // Arbiter is back in IDLE: a fresh c1 request gets its command next cycle.
    rd_burst(1, 29'h700, 1, 1, 64'hF000_0000_0000_0000, lat);
    chk("rstmid_regrant_lat", lat, 2);
    tick();

    chk("wrq_empty", wrq.size(), 0);
    chk("rdq_empty", rdq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
